// File: rtl/axi_counter_pkg.sv
// rtl/axi_counter_pkg.sv - shared types and AXI constants for the counter burst writer
package axi_counter_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_DATA,
    ST_RESP,
    ST_DONE
  } state_t;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;
  localparam int         BOUNDARY_4K    = 4096;

endpackage

// File: rtl/acbw_burst_calc.sv
// rtl/acbw_burst_calc.sv - beats of the next burst: min(remaining, MAX_BURST, room before 4 KB)
module acbw_burst_calc
  import axi_counter_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int MAX_BURST  = 16,
  parameter int CNT_WIDTH  = 32
) (
  input  logic [11:0]          addr_i,
  input  logic [CNT_WIDTH-1:0] remaining_i,
  output logic [8:0]           beats_o,
  output logic [7:0]           awlen_o
);

  localparam int BYTES    = DATA_WIDTH / 8;
  localparam int OFF_BITS = $clog2(BYTES);
  localparam int CW       = (CNT_WIDTH > 13) ? CNT_WIDTH : 13;

  logic [12:0]   room;
  logic [8:0]    cap;
  logic [CW-1:0] rem_w;

  always_comb begin
    room  = (13'(BOUNDARY_4K) - {1'b0, addr_i}) >> OFF_BITS;
    cap   = 9'(MAX_BURST);
    if (room < {4'b0000, cap}) begin
      cap = room[8:0];
    end
    rem_w   = CW'(remaining_i);
    beats_o = (rem_w < CW'(cap)) ? rem_w[8:0] : cap;
  end

  assign awlen_o = 8'(beats_o - 9'd1);

endmodule

// File: rtl/axi_counter_burst_writer.sv
// rtl/axi_counter_burst_writer.sv - writes an arithmetic counter pattern to memory as AXI4 INCR bursts
module axi_counter_burst_writer
  import axi_counter_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 64,
  parameter int MAX_BURST  = 16,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                    clk,
  input  logic                    areset,
  input  logic                    start_i,
  input  logic [ADDR_WIDTH-1:0]   base_addr_i,
  input  logic [CNT_WIDTH-1:0]    total_i,
  input  logic [DATA_WIDTH-1:0]   init_i,
  input  logic [DATA_WIDTH-1:0]   incr_i,
  output logic                    busy_o,
  output logic                    done_o,
  output logic                    err_o,
  output logic [ADDR_WIDTH-1:0]   m_awaddr_o,
  output logic [7:0]              m_awlen_o,
  output logic [1:0]              m_awburst_o,
  output logic                    m_awvalid_o,
  input  logic                    m_awready_i,
  output logic [DATA_WIDTH-1:0]   m_wdata_o,
  output logic [DATA_WIDTH/8-1:0] m_wstrb_o,
  output logic                    m_wlast_o,
  output logic                    m_wvalid_o,
  input  logic                    m_wready_i,
  input  logic [1:0]              m_bresp_i,
  input  logic                    m_bvalid_i,
  output logic                    m_bready_o
);

  localparam int BYTES    = DATA_WIDTH / 8;
  localparam int OFF_BITS = $clog2(BYTES);

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [CNT_WIDTH-1:0]  remaining_q, remaining_d;
  logic [DATA_WIDTH-1:0] cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] incr_q, incr_d;
  logic [8:0]            beats_q, beats_d;
  logic [8:0]            beat_idx_q, beat_idx_d;
  logic                  err_q, err_d;

  logic [8:0]            calc_beats;
  logic [7:0]            calc_awlen;
  logic                  last_beat;

  // addr_q and remaining_q only move in RESP, so the calc output is stable through ADDR
  acbw_burst_calc #(
    .DATA_WIDTH (DATA_WIDTH),
    .MAX_BURST  (MAX_BURST),
    .CNT_WIDTH  (CNT_WIDTH)
  ) u_burst_calc (
    .addr_i      (addr_q[11:0]),
    .remaining_i (remaining_q),
    .beats_o     (calc_beats),
    .awlen_o     (calc_awlen)
  );

  assign last_beat = (beat_idx_q == beats_q - 9'd1);

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      remaining_q <= '0;
      cnt_q       <= '0;
      incr_q      <= '0;
      beats_q     <= '0;
      beat_idx_q  <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      remaining_q <= remaining_d;
      cnt_q       <= cnt_d;
      incr_q      <= incr_d;
      beats_q     <= beats_d;
      beat_idx_q  <= beat_idx_d;
      err_q       <= err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    remaining_d = remaining_q;
    cnt_d       = cnt_q;
    incr_d      = incr_q;
    beats_d     = beats_q;
    beat_idx_d  = beat_idx_q;
    err_d       = err_q;

    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          addr_d      = base_addr_i & ~ADDR_WIDTH'(BYTES - 1);
          remaining_d = total_i;
          cnt_d       = init_i;
          incr_d      = incr_i;
          err_d       = 1'b0;
          state_d     = (total_i == '0) ? ST_DONE : ST_ADDR;
        end
      end
      ST_ADDR: begin
        if (m_awready_i) begin
          beats_d    = calc_beats;
          beat_idx_d = '0;
          state_d    = ST_DATA;
        end
      end
      ST_DATA: begin
        if (m_wready_i) begin
          cnt_d      = cnt_q + incr_q;
          beat_idx_d = beat_idx_q + 9'd1;
          if (last_beat) begin
            state_d = ST_RESP;
          end
        end
      end
      ST_RESP: begin
        if (m_bvalid_i) begin
          if (m_bresp_i != AXI_RESP_OKAY) begin
            err_d   = 1'b1;
            state_d = ST_DONE;
          end else begin
            remaining_d = remaining_q - CNT_WIDTH'(beats_q);
            addr_d      = addr_q + (ADDR_WIDTH'(beats_q) << OFF_BITS);
            state_d     = (remaining_q == CNT_WIDTH'(beats_q)) ? ST_DONE : ST_ADDR;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Payload outputs are forced to zero outside their valid phase
  assign busy_o      = (state_q == ST_ADDR) || (state_q == ST_DATA) || (state_q == ST_RESP);
  assign done_o      = (state_q == ST_DONE);
  assign err_o       = err_q;
  assign m_awburst_o = AXI_BURST_INCR;
  assign m_awvalid_o = (state_q == ST_ADDR);
  assign m_awaddr_o  = m_awvalid_o ? addr_q : '0;
  assign m_awlen_o   = m_awvalid_o ? calc_awlen : '0;
  assign m_wvalid_o  = (state_q == ST_DATA);
  assign m_wdata_o   = m_wvalid_o ? cnt_q : '0;
  assign m_wstrb_o   = {BYTES{m_wvalid_o}};
  assign m_wlast_o   = m_wvalid_o && last_beat;
  assign m_bready_o  = (state_q == ST_RESP);

endmodule

// File: tb/tb_axi_counter_burst_writer.sv
// tb/tb_axi_counter_burst_writer.sv - directed bench for axi_counter_burst_writer
module tb_axi_counter_burst_writer;

  localparam int DW = 32;
  localparam int AW = 64;
  localparam int MB = 4;
  localparam int CW = 32;

  logic          clk = 1'b0;
  logic          areset;
  logic          start_i;
  logic [AW-1:0] base_addr_i;
  logic [CW-1:0] total_i;
  logic [DW-1:0] init_i;
  logic [DW-1:0] incr_i;
  logic          busy_o, done_o, err_o;
  logic [AW-1:0] m_awaddr_o;
  logic [7:0]    m_awlen_o;
  logic [1:0]    m_awburst_o;
  logic          m_awvalid_o, m_awready_i;
  logic [DW-1:0] m_wdata_o;
  logic [3:0]    m_wstrb_o;
  logic          m_wlast_o, m_wvalid_o, m_wready_i;
  logic [1:0]    m_bresp_i;
  logic          m_bvalid_i, m_bready_o;

  logic wready_set;
  logic tog_en;
  logic tog = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) tog <= ~tog;
  assign m_wready_i = tog_en ? tog : wready_set;

  axi_counter_burst_writer #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .MAX_BURST  (MB),
    .CNT_WIDTH  (CW)
  ) dut (
    .clk         (clk),
    .areset      (areset),
    .start_i     (start_i),
    .base_addr_i (base_addr_i),
    .total_i     (total_i),
    .init_i      (init_i),
    .incr_i      (incr_i),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .err_o       (err_o),
    .m_awaddr_o  (m_awaddr_o),
    .m_awlen_o   (m_awlen_o),
    .m_awburst_o (m_awburst_o),
    .m_awvalid_o (m_awvalid_o),
    .m_awready_i (m_awready_i),
    .m_wdata_o   (m_wdata_o),
    .m_wstrb_o   (m_wstrb_o),
    .m_wlast_o   (m_wlast_o),
    .m_wvalid_o  (m_wvalid_o),
    .m_wready_i  (m_wready_i),
    .m_bresp_i   (m_bresp_i),
    .m_bvalid_i  (m_bvalid_i),
    .m_bready_o  (m_bready_o)
  );

  logic [63:0] aw_addr_q[$];
  logic [7:0]  aw_len_q[$];
  logic [31:0] w_data_q[$];
  logic        w_last_q[$];
  int aw_cnt = 0, wlast_cnt = 0, done_cnt = 0;
  int aw_stall_viol = 0, w_stall_viol = 0, aw_stall_cycles = 0, w_stall_cycles = 0;
  int w_before_aw = 0, strb_bad = 0;
  logic        prev_aw_stall = 1'b0, prev_w_stall = 1'b0, prev_wlast = 1'b0;
  logic [63:0] prev_awaddr = '0;
  logic [7:0]  prev_awlen = '0;
  logic [31:0] prev_wdata = '0;

  always @(negedge clk) begin
    if (areset) begin
      prev_aw_stall = 1'b0;
      prev_w_stall  = 1'b0;
      wlast_cnt     = aw_cnt;
    end else begin
      if (prev_aw_stall && !(m_awvalid_o && m_awaddr_o == prev_awaddr && m_awlen_o == prev_awlen))
        aw_stall_viol++;
      if (prev_w_stall && !(m_wvalid_o && m_wdata_o == prev_wdata && m_wlast_o == prev_wlast))
        w_stall_viol++;
      if (m_wvalid_o && m_wstrb_o != 4'hF) strb_bad++;
      if (done_o) done_cnt++;
      if (m_awvalid_o && m_awready_i) begin
        aw_addr_q.push_back(m_awaddr_o);
        aw_len_q.push_back(m_awlen_o);
        aw_cnt++;
      end
      if (m_wvalid_o && m_wready_i) begin
        if (aw_cnt <= wlast_cnt) w_before_aw++;
        w_data_q.push_back(m_wdata_o);
        w_last_q.push_back(m_wlast_o);
        if (m_wlast_o) wlast_cnt++;
      end
      prev_aw_stall = m_awvalid_o && !m_awready_i;
      prev_w_stall  = m_wvalid_o && !m_wready_i;
      if (prev_aw_stall) aw_stall_cycles++;
      if (prev_w_stall) w_stall_cycles++;
      prev_awaddr = m_awaddr_o;
      prev_awlen  = m_awlen_o;
      prev_wdata  = m_wdata_o;
      prev_wlast  = m_wlast_o;
    end
  end

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] aw_addr_at(input int i);
    return (i < aw_addr_q.size()) ? aw_addr_q[i] : 64'hx;
  endfunction
  function automatic logic [63:0] aw_len_at(input int i);
    return (i < aw_len_q.size()) ? {56'h0, aw_len_q[i]} : 64'hx;
  endfunction
  function automatic logic [63:0] w_data_at(input int i);
    return (i < w_data_q.size()) ? {32'h0, w_data_q[i]} : 64'hx;
  endfunction
  function automatic logic [63:0] w_last_at(input int i);
    return (i < w_last_q.size()) ? {63'h0, w_last_q[i]} : 64'hx;
  endfunction

  task automatic start_job(input logic [63:0] base, input logic [31:0] total,
                           input logic [31:0] init, input logic [31:0] incr);
    @(posedge clk); #1;
    start_i     = 1'b1;
    base_addr_i = base;
    total_i     = total;
    init_i      = init;
    incr_i      = incr;
    @(posedge clk); #1;
    start_i = 1'b0;
  endtask

  task automatic wait_done(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (done_o) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  int ab, wb;
  bit ok;

  initial begin
    areset = 1'b1; start_i = 1'b0; base_addr_i = '0; total_i = '0; init_i = '0; incr_i = '0;
    m_awready_i = 1'b1; wready_set = 1'b1; tog_en = 1'b0; m_bvalid_i = 1'b1; m_bresp_i = 2'b00;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", busy_o, 0);
    check("rst_done", done_o, 0);
    check("rst_awvalid", m_awvalid_o, 0);
    check("rst_wvalid", m_wvalid_o, 0);
    check("rst_awburst", m_awburst_o, 2'b01);
    check("rst_awlen", m_awlen_o, 0);
    check("rst_bready", m_bready_o, 0);
    @(posedge clk); #1;
    areset = 1'b0;

    // single-word job
    ab = aw_addr_q.size(); wb = w_data_q.size();
    start_job(64'h43C1_0000, 1, 32'hC2AA_EE2A, 4);
    check("j1_busy", busy_o, 1);
    wait_done(ok);
    check("j1_done", ok, 1);
    check("j1_err", err_o, 0);
    check("j1_awn", aw_addr_q.size() - ab, 1);
    check("j1_awaddr", aw_addr_at(ab), 64'h43C1_0000);
    check("j1_awlen", aw_len_at(ab), 0);
    check("j1_wn", w_data_q.size() - wb, 1);
    check("j1_wdata", w_data_at(wb), 32'hC2AA_EE2A);
    check("j1_wlast", w_last_at(wb), 1);
    @(negedge clk);
    check("j1_done_pulse", done_o, 0);
    check("j1_busy_end", busy_o, 0);

    // ten words in three bursts, with a start pulse while busy that must be ignored
    ab = aw_addr_q.size(); wb = w_data_q.size();
    start_job(64'h1000, 10, 0, 1);
    repeat (2) begin @(posedge clk); #1; end
    start_i = 1'b1; base_addr_i = 64'h9000; total_i = 1;
    @(posedge clk); #1;
    start_i = 1'b0;
    wait_done(ok);
    check("j2_done", ok, 1);
    check("j2_awn", aw_addr_q.size() - ab, 3);
    check("j2_aw0", aw_addr_at(ab), 64'h1000);
    check("j2_len0", aw_len_at(ab), 3);
    check("j2_aw1", aw_addr_at(ab + 1), 64'h1010);
    check("j2_len1", aw_len_at(ab + 1), 3);
    check("j2_aw2", aw_addr_at(ab + 2), 64'h1020);
    check("j2_len2", aw_len_at(ab + 2), 1);
    check("j2_wn", w_data_q.size() - wb, 10);
    for (int i = 0; i < 10; i++) begin
      check($sformatf("j2_wdata%0d", i), w_data_at(wb + i), i);
      check($sformatf("j2_wlast%0d", i), w_last_at(wb + i), (i == 3 || i == 7 || i == 9) ? 1 : 0);
    end
    repeat (3) begin @(posedge clk); #1; end
    check("j2_no_ghost_job", busy_o, 0);
    check("j2_no_ghost_aw", aw_addr_q.size() - ab, 3);

    // 4 KB split
    ab = aw_addr_q.size(); wb = w_data_q.size();
    start_job(64'h0FF8, 4, 0, 1);
    wait_done(ok);
    check("j3_done", ok, 1);
    check("j3_awn", aw_addr_q.size() - ab, 2);
    check("j3_aw0", aw_addr_at(ab), 64'h0FF8);
    check("j3_len0", aw_len_at(ab), 1);
    check("j3_aw1", aw_addr_at(ab + 1), 64'h1000);
    check("j3_len1", aw_len_at(ab + 1), 1);
    check("j3_wn", w_data_q.size() - wb, 4);

    // error response aborts job
    m_bresp_i = 2'b10;
    ab = aw_addr_q.size(); wb = w_data_q.size();
    start_job(64'h2000, 8, 0, 1);
    wait_done(ok);
    check("j4_done", ok, 1);
    check("j4_err", err_o, 1);
    check("j4_awn", aw_addr_q.size() - ab, 1);
    check("j4_wn", w_data_q.size() - wb, 4);
    @(negedge clk);
    check("j4_err_sticky", err_o, 1);
    m_bresp_i = 2'b00;

    // counter wrap; accepted start clears err
    ab = aw_addr_q.size(); wb = w_data_q.size();
    start_job(64'h3000, 3, 32'hFFFF_FFFE, 1);
    check("j5_err_clr", err_o, 0);
    wait_done(ok);
    check("j5_done", ok, 1);
    check("j5_len", aw_len_at(ab), 2);
    check("j5_w0", w_data_at(wb), 32'hFFFF_FFFE);
    check("j5_w1", w_data_at(wb + 1), 32'hFFFF_FFFF);
    check("j5_w2", w_data_at(wb + 2), 32'h0000_0000);
    check("j5_err", err_o, 0);

    // zero-length job
    ab = aw_addr_q.size();
    start_job(64'h4000, 0, 0, 1);
    check("j6_busy", busy_o, 0);
    check("j6_done_now", done_o, 1);
    wait_done(ok);
    check("j6_done", ok, 1);
    @(negedge clk);
    check("j6_done_pulse", done_o, 0);
    check("j6_awn", aw_addr_q.size() - ab, 0);

    // AW stalled 5 cycles, W ready toggling
    m_awready_i = 1'b0;
    ab = aw_addr_q.size(); wb = w_data_q.size();
    start_job(64'h5000, 6, 32'h100, 32'h10);
    repeat (5) begin @(posedge clk); #1; end
    check("j7_aw_held", m_awvalid_o, 1);
    check("j7_aw_wait", aw_addr_q.size() - ab, 0);
    check("j7_no_w", m_wvalid_o, 0);
    m_awready_i = 1'b1;
    tog_en = 1'b1;
    wait_done(ok);
    tog_en = 1'b0;
    check("j7_done", ok, 1);
    check("j7_aw0", aw_addr_at(ab), 64'h5000);
    check("j7_len0", aw_len_at(ab), 3);
    check("j7_aw1", aw_addr_at(ab + 1), 64'h5010);
    check("j7_len1", aw_len_at(ab + 1), 1);
    for (int i = 0; i < 6; i++) begin
      check($sformatf("j7_wdata%0d", i), w_data_at(wb + i), 32'h100 + 32'h10 * i);
      check($sformatf("j7_wlast%0d", i), w_last_at(wb + i), (i == 3 || i == 5) ? 1 : 0);
    end
    check("j7_aw_stalls_seen", aw_stall_cycles >= 5, 1);
    check("j7_w_stalls_seen", w_stall_cycles > 0, 1);
    check("j7_aw_stable", aw_stall_viol, 0);
    check("j7_w_stable", w_stall_viol, 0);

    // reset mid-DATA
    start_job(64'h6000, 8, 0, 1);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (m_wvalid_o) begin
        ok = 1'b1;
        break;
      end
    end
    check("j8_in_data", ok, 1);
    ab = done_cnt;
    @(posedge clk); #1;
    areset = 1'b1;
    #1;
    check("j8_rst_busy", busy_o, 0);
    check("j8_rst_done", done_o, 0);
    check("j8_rst_err", err_o, 0);
    check("j8_rst_awvalid", m_awvalid_o, 0);
    check("j8_rst_awaddr", m_awaddr_o, 0);
    check("j8_rst_awlen", m_awlen_o, 0);
    check("j8_rst_awburst", m_awburst_o, 2'b01);
    check("j8_rst_wvalid", m_wvalid_o, 0);
    check("j8_rst_wdata", m_wdata_o, 0);
    check("j8_rst_wstrb", m_wstrb_o, 0);
    check("j8_rst_wlast", m_wlast_o, 0);
    check("j8_rst_bready", m_bready_o, 0);
    repeat (2) @(posedge clk);
    #1;
    areset = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    check("j8_no_done", done_cnt, ab);
    check("j8_idle", busy_o, 0);

    // fresh job after reset, unaligned base
    ab = aw_addr_q.size(); wb = w_data_q.size();
    start_job(64'h7002, 2, 5, 5);
    wait_done(ok);
    check("j9_done", ok, 1);
    check("j9_aw", aw_addr_at(ab), 64'h7000);
    check("j9_len", aw_len_at(ab), 1);
    check("j9_w0", w_data_at(wb), 5);
    check("j9_w1", w_data_at(wb + 1), 10);
    check("j9_last1", w_last_at(wb + 1), 1);

    check("w_before_aw", w_before_aw, 0);
    check("wstrb_all_ones", strb_bad, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
